// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, datapath widths, arbiter FSM states
// and the operand-B shift masking helper.
package alu_pkg;

  localparam int XLEN    = 32;
  localparam int SHAMT_W = 5;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLL = 3'b101,
    OP_SRL = 3'b110,
    OP_SRA = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } arb_state_t;

  function automatic logic is_shift(input alu_op_t op);
    case (op)
      OP_SLL, OP_SRL, OP_SRA: is_shift = 1'b1;
      default:                is_shift = 1'b0;
    endcase
  endfunction

  // Shifts only ever see the low shift-amount bits of operand B.
  function automatic logic [XLEN-1:0] mask_b(input alu_op_t op, input logic [XLEN-1:0] b);
    if (is_shift(op)) begin
      mask_b = {{(XLEN-SHAMT_W){1'b0}}, b[SHAMT_W-1:0]};
    end else begin
      mask_b = b;
    end
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr,
// wrapping around, reported as one-hot grant, index and an any flag.
module rr_pick #(
  parameter int N    = 2,
  parameter int ID_W = 1
) (
  input  logic [N-1:0]    valid,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] idx,
  output logic            any
);

  logic [ID_W-1:0] slot_s;
  logic            hit_s;

  // Scan N slots from ptr; only the first valid slot sets the grant.
  always_comb begin
    grant  = '0;
    idx    = '0;
    any    = 1'b0;
    slot_s = '0;
    hit_s  = 1'b0;
    for (int k = 0; k < N; k++) begin
      slot_s        = ID_W'((int'(ptr) + k) % N);
      hit_s         = valid[slot_s] & ~any;
      grant[slot_s] = grant[slot_s] | hit_s;
      idx           = hit_s ? slot_s : idx;
      any           = any | valid[slot_s];
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NUM_REQ requesters,
// one operation in flight; result and flags are registered and held until accepted.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0][2:0]       req_op,
  input  logic [NUM_REQ-1:0][31:0]      req_a,
  input  logic [NUM_REQ-1:0][31:0]      req_b,
  output logic [NUM_REQ-1:0]            rsp_valid,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic [31:0]                   rsp_c,
  output logic                          rsp_zero,
  output logic                          rsp_lt,
  output logic                          rsp_slt,
  output logic [2:0]                    alu_operation,
  output logic [31:0]                   alu_a,
  output logic [31:0]                   alu_b,
  input  logic [31:0]                   alu_c,
  input  logic                          alu_zero,
  input  logic                          alu_less_than,
  input  logic                          alu_signed_less_than,
  output logic                          busy
);

  localparam int ID_W = $clog2(NUM_REQ);

  arb_state_t          state_r, state_s;
  logic [ID_W-1:0]     rr_ptr_r, rr_ptr_s;
  logic [ID_W-1:0]     owner_r, owner_s;
  logic [ID_W-1:0]     next_ptr_s;
  alu_op_t             op_r;
  logic [XLEN-1:0]     a_r, b_r, rsp_c_r;
  logic                zero_r, lt_r, slt_r, busy_r;
  logic [NUM_REQ-1:0]  rsp_valid_r, rsp_valid_s, req_ready_s;
  logic                load_s, capture_s;

  logic [NUM_REQ-1:0]  idle_grant_s, resp_grant_s;
  logic [ID_W-1:0]     idle_idx_s, resp_idx_s;
  logic                idle_any_s, resp_any_s;

  assign next_ptr_s = (owner_r == ID_W'(NUM_REQ-1)) ? '0 : owner_r + ID_W'(1);

  rr_pick #(.N(NUM_REQ), .ID_W(ID_W)) u_pick_idle (
    .valid (req_valid),
    .ptr   (rr_ptr_r),
    .grant (idle_grant_s),
    .idx   (idle_idx_s),
    .any   (idle_any_s)
  );

  // Re-arbitration from the advanced pointer while the current result retires.
  rr_pick #(.N(NUM_REQ), .ID_W(ID_W)) u_pick_resp (
    .valid (req_valid),
    .ptr   (next_ptr_s),
    .grant (resp_grant_s),
    .idx   (resp_idx_s),
    .any   (resp_any_s)
  );

  // Next-state, grant and load/capture strobes.
  always_comb begin
    state_s     = state_r;
    rr_ptr_s    = rr_ptr_r;
    owner_s     = owner_r;
    req_ready_s = '0;
    load_s      = 1'b0;
    capture_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (idle_any_s) begin
          req_ready_s = idle_grant_s;
          owner_s     = idle_idx_s;
          load_s      = 1'b1;
          state_s     = ST_EXEC;
        end else begin
          state_s     = ST_IDLE;
        end
      end
      ST_EXEC: begin
        capture_s = 1'b1;
        state_s   = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready[owner_r]) begin
          rr_ptr_s = next_ptr_s;
          if (resp_any_s) begin
            req_ready_s = resp_grant_s;
            owner_s     = resp_idx_s;
            load_s      = 1'b1;
            state_s     = ST_EXEC;
          end else begin
            state_s     = ST_IDLE;
          end
        end else begin
          state_s = ST_RESP;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Response valid for the next cycle, one-hot on the owner.
  always_comb begin
    rsp_valid_s = '0;
    if (state_s == ST_RESP) begin
      rsp_valid_s[owner_s] = 1'b1;
    end else begin
      rsp_valid_s = '0;
    end
  end

  // Control state: FSM, round-robin pointer, owner, busy and response valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      rr_ptr_r    <= '0;
      owner_r     <= '0;
      busy_r      <= 1'b0;
      rsp_valid_r <= '0;
    end else begin
      state_r     <= state_s;
      rr_ptr_r    <= rr_ptr_s;
      owner_r     <= owner_s;
      busy_r      <= (state_s != ST_IDLE);
      rsp_valid_r <= rsp_valid_s;
    end
  end

  // Operand latch on grant and result/flag capture at the end of EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r    <= OP_ADD;
      a_r     <= '0;
      b_r     <= '0;
      rsp_c_r <= '0;
      zero_r  <= 1'b0;
      lt_r    <= 1'b0;
      slt_r   <= 1'b0;
    end else begin
      if (load_s) begin
        op_r <= alu_op_t'(req_op[owner_s]);
        a_r  <= req_a[owner_s];
        b_r  <= mask_b(alu_op_t'(req_op[owner_s]), req_b[owner_s]);
      end
      if (capture_s) begin
        rsp_c_r <= alu_c;
        zero_r  <= alu_zero;
        lt_r    <= alu_less_than;
        slt_r   <= alu_signed_less_than;
      end
    end
  end

  // Grant is combinational (depends on rsp_ready in RESP) and held low in reset.
  assign req_ready     = rst_n ? req_ready_s : '0;
  assign rsp_valid     = rsp_valid_r;
  assign rsp_c         = rsp_c_r;
  assign rsp_zero      = zero_r;
  assign rsp_lt        = lt_r;
  assign rsp_slt       = slt_r;
  assign alu_operation = op_r;
  assign alu_a         = a_r;
  assign alu_b         = b_r;
  assign busy          = busy_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: bench-side ALU, directed scenarios and
// randomized traffic checked against a round-robin/arithmetic reference model.
module tb_alu_arbiter;

  localparam int N = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N-1:0][2:0] req_op;
  logic [N-1:0][31:0] req_a, req_b;
  logic [31:0]       rsp_c, alu_a, alu_b, alu_c;
  logic [2:0]        alu_operation;
  logic              rsp_zero, rsp_lt, rsp_slt, busy;
  logic              alu_zero, alu_less_than, alu_signed_less_than;

  typedef struct {
    int          owner;
    logic [31:0] c;
    logic        z, lt, slt;
    int          acc_cyc;
  } exp_t;

  exp_t         sb_q[$];
  exp_t         mon_e;
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           last_served = N - 1;
  int           acc_count[N];
  int           seen[N];
  bit           rand_mode = 1'b0;
  bit [N-1:0]   repeat_mode = '0;

  alu_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_c(rsp_c), .rsp_zero(rsp_zero), .rsp_lt(rsp_lt), .rsp_slt(rsp_slt),
    .alu_operation(alu_operation), .alu_a(alu_a), .alu_b(alu_b),
    .alu_c(alu_c), .alu_zero(alu_zero), .alu_less_than(alu_less_than),
    .alu_signed_less_than(alu_signed_less_than), .busy(busy)
  );

  always #5 clk = ~clk;

  // External ALU: shifts use the full alu_b so an unmasked operand shows up.
  always_comb begin
    alu_c = 32'h0;
    case (alu_operation)
      3'b000:  alu_c = alu_a + alu_b;
      3'b001:  alu_c = alu_a - alu_b;
      3'b010:  alu_c = alu_a & alu_b;
      3'b011:  alu_c = alu_a | alu_b;
      3'b100:  alu_c = alu_a ^ alu_b;
      3'b101:  alu_c = alu_a << alu_b;
      3'b110:  alu_c = alu_a >> alu_b;
      default: alu_c = $signed(alu_a) >>> alu_b;
    endcase
    alu_zero             = (alu_c == 32'h0);
    alu_less_than        = (alu_a < alu_b);
    alu_signed_less_than = ($signed(alu_a) < $signed(alu_b));
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t ref_model(int owner, logic [2:0] op, logic [31:0] a, logic [31:0] b, int acc);
    exp_t        e;
    int unsigned sh;
    logic [31:0] bc;
    sh = b % 32;
    bc = (op >= 3'd5) ? 32'(sh) : b;
    case (op)
      3'd0:    e.c = a + b;
      3'd1:    e.c = a - b;
      3'd2:    e.c = a & b;
      3'd3:    e.c = a | b;
      3'd4:    e.c = a ^ b;
      3'd5:    e.c = a << sh;
      3'd6:    e.c = a >> sh;
      default: e.c = $signed(a) >>> sh;
    endcase
    e.z       = (e.c == 32'h0);
    e.lt      = (a < bc);
    e.slt     = ($signed(a) < $signed(bc));
    e.owner   = owner;
    e.acc_cyc = acc;
    return e;
  endfunction

  function automatic int pick(logic [N-1:0] v, int start);
    for (int k = 0; k < N; k++) begin
      if (v[(start + k) % N]) return (start + k) % N;
    end
    return 0;
  endfunction

  function automatic int acc_sum();
    int s = 0;
    for (int i = 0; i < N; i++) s += acc_count[i];
    return s;
  endfunction

  // Monitor: retires responses, then predicts and records the next grant.
  initial begin
    for (int i = 0; i < N; i++) acc_count[i] = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb_q.delete();
        last_served = N - 1;
      end else begin
        cyc++;
        chk("busy", 32'(busy), 32'(sb_q.size() != 0));
        if (sb_q.size() != 0) begin
          mon_e = sb_q[0];
          if (rsp_valid != '0) begin
            chk("rsp_valid", 32'(rsp_valid), 32'(1) << mon_e.owner);
            chk("rsp_c", rsp_c, mon_e.c);
            chk("rsp_zero", 32'(rsp_zero), 32'(mon_e.z));
            chk("rsp_lt", 32'(rsp_lt), 32'(mon_e.lt));
            chk("rsp_slt", 32'(rsp_slt), 32'(mon_e.slt));
            if (rsp_ready[mon_e.owner]) begin
              void'(sb_q.pop_front());
              last_served = mon_e.owner;
            end
          end else begin
            chk("rsp_latency", 32'(cyc - mon_e.acc_cyc), 32'd1);
            if (cyc - mon_e.acc_cyc > 1) begin
              void'(sb_q.pop_front());
              last_served = mon_e.owner;
            end
          end
        end else begin
          chk("rsp_valid_idle", 32'(rsp_valid), 32'd0);
        end
        if (sb_q.size() == 0 && req_valid != '0) begin
          int g;
          g = pick(req_valid, (last_served + 1) % N);
          chk("req_ready", 32'(req_ready), 32'(1) << g);
          sb_q.push_back(ref_model(g, req_op[g], req_a[g], req_b[g], cyc));
          acc_count[g]++;
        end else begin
          chk("req_ready_zero", 32'(req_ready), 32'd0);
        end
      end
    end
  end

  task automatic issue(input int i, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op[i]    = op;
    req_a[i]     = a;
    req_b[i]     = b;
    req_valid[i] = 1'b1;
  endtask

  task automatic step();
    logic [31:0] a, b;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc_count[i] != seen[i]) begin
        seen[i]      = acc_count[i];
        req_valid[i] = repeat_mode[i];
      end
      if (rand_mode) begin
        rsp_ready[i] = ($urandom_range(0, 3) != 0);
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          a = $urandom;
          case ($urandom_range(0, 3))
            0:       b = a;
            1:       b = 32'($urandom_range(0, 40));
            default: b = $urandom;
          endcase
          issue(i, 3'($urandom_range(0, 7)), a, b);
        end
      end
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((sb_q.size() != 0 || req_valid != '0) && n < budget) begin
      step();
      n++;
    end
    chk("drain", 32'(sb_q.size()) + 32'(req_valid != '0), 32'd0);
  endtask

  initial begin
    int b0, b1, c0, n;
    rst_n = 1'b0;
    req_valid = '0; rsp_ready = '1;
    req_op = '0; req_a = '0; req_b = '0;
    for (int i = 0; i < N; i++) seen[i] = 0;
    #3;
    issue(0, 3'd0, 32'd1, 32'd2);
    issue(1, 3'd0, 32'd3, 32'd4);
    #20;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_c", rsp_c, 32'd0);
    chk("rst_flags", {29'd0, rsp_zero, rsp_lt, rsp_slt}, 32'd0);
    chk("rst_alu_drive", {29'd0, alu_operation} | alu_a | alu_b, 32'd0);
    req_valid = '0;
    @(posedge clk); #3;
    rst_n = 1'b1;

    // Single add with immediate grant.
    step();
    issue(0, 3'd0, 32'd5, 32'd7);
    #1;
    chk("add_grant", 32'(req_ready), 32'd1);
    drain(20);

    // Reset during EXEC; pointer returns to requester 0.
    step();
    issue(0, 3'd0, 32'd1, 32'd1);
    step();
    chk("midop_busy", 32'(busy), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midop_busy_rst", 32'(busy), 32'd0);
    chk("midop_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midop_rsp_c", rsp_c, 32'd0);
    chk("midop_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    @(posedge clk); #3;
    rst_n = 1'b1;
    b0 = acc_count[0]; b1 = acc_count[1];
    issue(0, 3'd0, 32'd2, 32'd3);
    issue(1, 3'd0, 32'd4, 32'd5);
    step();
    chk("post_rst_grant0", 32'(acc_count[0] - b0), 32'd1);
    chk("post_rst_grant1", 32'(acc_count[1] - b1), 32'd0);
    drain(20);

    // Contention: both requesters continuously present sub 3-3.
    repeat_mode = '1;
    step();
    issue(0, 3'd1, 32'd3, 32'd3);
    issue(1, 3'd1, 32'd3, 32'd3);
    c0 = acc_sum();
    n = 0;
    while (acc_sum() == c0 && n < 10) begin step(); n++; end
    c0 = acc_sum();
    repeat (16) step();
    chk("throughput", 32'(acc_sum() - c0), 32'd8);
    repeat_mode = '0;
    drain(20);

    // Backpressure on requester 1 with an arithmetic shift.
    rsp_ready = 2'b01;
    step();
    issue(1, 3'd7, 32'h8000_0000, 32'hFFFF_FF24);
    n = 0;
    while (rsp_valid[1] !== 1'b1 && n < 10) begin step(); n++; end
    chk("bp_rsp_valid", 32'(rsp_valid), 32'd2);
    issue(0, 3'd0, 32'd1, 32'd2);
    repeat (5) begin
      step();
      chk("bp_hold_valid", 32'(rsp_valid), 32'd2);
      chk("bp_hold_c", rsp_c, 32'hF800_0000);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = '1;
    drain(20);

    // Signed versus unsigned compare.
    step();
    issue(0, 3'd1, 32'hFFFF_FFFF, 32'd1);
    drain(20);

    // Randomized traffic and backpressure.
    rand_mode = 1'b1;
    repeat (400) step();
    rand_mode = 1'b0;
    rsp_ready = '1;
    drain(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational 32-bit ALU between NUM_REQ requesters, e.g. the execute path and the branch-compare path.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- A round-robin FSM grants one request, drives the ALU for one cycle and registers the result and flags, then holds the response until it is accepted.
- Sits between the requesters and the alu instance. alu_a, alu_b, alu_operation and alu_c are driven/consumed as 32-bit vectors.

Parameters:
- NUM_REQ, 2, number of requesters (legal range 2..8).
- ID_W, $clog2(NUM_REQ), localparam; width of the owner index and round-robin pointer.

Ports:
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  [NUM_REQ-1:0]  request present per requester
- req_ready  output  [NUM_REQ-1:0]  one-hot grant; request accepted when valid&ready
- req_op  input  [NUM_REQ-1:0][2:0]  ALU operation code per requester
- req_a  input  [NUM_REQ-1:0][31:0]  operand A per requester
- req_b  input  [NUM_REQ-1:0][31:0]  operand B per requester
- rsp_valid  output  [NUM_REQ-1:0]  one-hot: result available for owner
- rsp_ready  input  [NUM_REQ-1:0]  requester accepts result
- rsp_c  output  32  registered ALU result (shared bus, qualified by rsp_valid)
- rsp_zero  output  1  registered zero flag
- rsp_lt  output  1  registered unsigned less-than
- rsp_slt  output  1  registered signed less-than
- alu_operation  output  3  to ALU
- alu_a  output  32  to ALU
- alu_b  output  32  to ALU
- alu_c  input  32  from ALU
- alu_zero  input  1  from ALU
- alu_less_than  input  1  from ALU
- alu_signed_less_than  input  1  from ALU
- busy  output  1  FSM not in IDLE

Behaviour:
- Op encoding:
  - 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 sll, 110 srl, 111 sra.
- FSM states:
  - IDLE: if any req_valid, pick the first requester at or after rr_ptr (wrapping). Assert its req_ready combinationally, latch op/a/b/owner, go EXEC. Otherwise stay.
  - EXEC: drive alu_* from the operand registers. Capture alu_c and the three flags into the rsp registers at the clock edge, go RESP. req_ready is all zero.
  - RESP: rsp_valid[owner]=1. rsp_c and the flags are stable until accepted.
    - On rsp_ready[owner]: rr_ptr <= owner+1 mod NUM_REQ.
    - In that same cycle, arbitrate again from the new pointer value. If any req_valid, grant it and go EXEC, otherwise go IDLE.
    - Without rsp_ready[owner], stay; req_ready is all zero.
- Latency and throughput:
  - Request accepted at edge N; rsp_valid rises after edge N+1.
  - Maximum throughput is one op per 2 cycles.
- Shift masking: for ops 101/110/111, alu_b = {27'b0, b[4:0]}. Otherwise alu_b = b unmodified.
- Idle ALU drive: outside EXEC, alu_* are driven from the operand registers (no X). The flags are only captured in EXEC.
- Fairness: a requester that keeps req_valid high is granted within NUM_REQ grants.
- Signal rules:
  - rsp_ready on non-owners is ignored.
  - req_op/a/b are don't-care when valid is low.
  - Requesters must hold valid/op/a/b stable until ready.
- Reset (async, any state including mid-EXEC/RESP):
  - Go to IDLE, rr_ptr=0.
  - req_ready=0, rsp_valid=0, rsp_c=0, rsp_zero=0, rsp_lt=0, rsp_slt=0, busy=0.
  - Operand registers 0 (op=000).
  - Any in-flight result is dropped.
- Combinational path: req_ready depends on rsp_ready in RESP. Documented; requesters must not loop ready to valid.

Decomposition:
- Shared package alu_pkg:
  - typedef enum logic [2:0] alu_op_t with the eight codes above.
  - localparam XLEN=32 and SHAMT_W=5.
  - typedef enum for FSM states IDLE/EXEC/RESP.
- The existing ALU should be migrated to alu_pkg.
- Sub-module rr_pick:
  - Combinational round-robin picker.
  - Inputs: valid vector and pointer. Outputs: one-hot grant, index, any.
  - Reused for each arbitration point.

Test Plan:
- Single add: req0 op=000 a=5 b=7, rsp_ready=1 -> req_ready[0] same cycle; rsp_valid[0] two edges later; rsp_c=12, zero=0, lt=1, slt=1.
- Contention: req0 and req1 valid from reset, each with op=001 a=b=3 and rsp_ready=1 -> grants alternate 0,1,0,1. Each result rsp_c=0, zero=1. One op per 2 cycles.
- Backpressure: req1 op=111 a=32'h8000_0000 b=32'hFFFF_FF24 (shamt 4), rsp_ready=0 for 5 cycles -> rsp_valid[1] held, rsp_c=32'hF800_0000 stable, req_ready=0. Accepted on rsp_ready.
- Signed vs unsigned compare: op=001 a=32'hFFFF_FFFF b=1 -> rsp_c=32'hFFFF_FFFE, lt=0, slt=1.
- Reset mid-op: assert rst_n=0 during EXEC -> asynchronously, busy=0, rsp_valid=0, rsp_c=0. After release, the first grant goes to req0.
